sigmoid_grad: RTL and testbench



---
 rtl/sigmoid_grad.sv | 87 ++++++++
 tb/tb_sigmoid_grad.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sigmoid_grad.sv
// Sigmoid backward pass: g = e * y * (1 - y), three-stage multicycle datapath
// started by a rising edge on dv_in and finished with a one-cycle dv_out pulse.
module sigmoid_grad #(
   parameter int IBIT = 32,
   parameter int OBIT = 11,
   parameter int FBIT = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   dv_in,
   input  logic signed [OBIT-1:0] sigin,
   input  logic signed [IBIT-1:0] errin,
   output logic                   dv_out,
   output logic signed [IBIT-1:0] gradout,
   output logic                   busy
);

   localparam int PW = 2 * FBIT;
   localparam int MW = IBIT + FBIT - 1;
   localparam logic [FBIT:0]          One = {1'b1, {FBIT{1'b0}}};
   localparam logic signed [MW-1:0]   Rnd = MW'(2 ** (FBIT - 1));

   typedef enum logic [1:0] {StIdle, StMul1, StMul2, StDone} state_e;

   state_e                 state;
   logic                   bfr_dv;
   logic signed [OBIT-1:0] y_r;
   logic signed [IBIT-1:0] e_r;
   logic [PW-1:0]          p_r;
   logic signed [MW-1:0]   m_r;

   logic [FBIT:0]          y_c;
   logic [FBIT:0]          one_m_y;
   logic [PW-1:0]          d;
   logic signed [MW-1:0]   m_rnd;

   always_comb begin
      // Negative activations are out of range and clamp to zero.
      y_c     = y_r[OBIT-1] ? '0 : (FBIT + 1)'(y_r);
      one_m_y = One - y_c;
      d       = p_r >> FBIT;
      m_rnd   = m_r + Rnd;
   end

   assign busy = (state != StIdle);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= StIdle;
         bfr_dv  <= 1'b0;
         dv_out  <= 1'b0;
         gradout <= '0;
         y_r     <= '0;
         e_r     <= '0;
         p_r     <= '0;
         m_r     <= '0;
      end else begin
         bfr_dv <= dv_in;
         dv_out <= 1'b0;
         case (state)
            StIdle: begin
               if (!bfr_dv && dv_in) begin
                  y_r   <= sigin;
                  e_r   <= errin;
                  state <= StMul1;
               end
            end
            StMul1: begin
               p_r   <= PW'(y_c) * PW'(one_m_y);
               state <= StMul2;
            end
            StMul2: begin
               // d is at most 2^(FBIT-2), so the product fits MW bits signed.
               m_r   <= MW'(e_r) * $signed(MW'(d));
               state <= StDone;
            end
            StDone: begin
               gradout <= IBIT'(m_rnd >>> FBIT);
               dv_out  <= 1'b1;
               state   <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sigmoid_grad.sv
// Directed self-checking bench for sigmoid_grad with hand-computed gradients.
module tb_sigmoid_grad;

   logic               clk;
   logic               rst;
   logic               dv_in;
   logic signed [10:0] sigin;
   logic signed [31:0] errin;
   logic               dv_out;
   logic signed [31:0] gradout;
   logic               busy;

   int checks = 0;
   int errors = 0;
   int pulses;

   sigmoid_grad #(
      .IBIT(32),
      .OBIT(11),
      .FBIT(10)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .dv_in  (dv_in),
      .sigin  (sigin),
      .errin  (errin),
      .dv_out (dv_out),
      .gradout(gradout),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   // One full transaction with latency/busy checks; inputs are scrambled after E0.
   task automatic run_vec(input string tag, input int y, input int e, input int exp);
      sigin = y[10:0];
      errin = e;
      dv_in = 1'b1;
      tick();  // E0
      chk({tag, " busy@E0"}, 32'(busy), 32'd1);
      chk({tag, " dv@E0"}, 32'(dv_out), 32'd0);
      dv_in = 1'b0;
      sigin = 11'sd300;
      errin = -32'sd99999;
      tick();  // E1
      chk({tag, " dv@E1"}, 32'(dv_out), 32'd0);
      tick();  // E2
      chk({tag, " busy@E2"}, 32'(busy), 32'd1);
      chk({tag, " dv@E2"}, 32'(dv_out), 32'd0);
      tick();  // E3
      chk({tag, " dv@E3"}, 32'(dv_out), 32'd1);
      chk({tag, " grad@E3"}, gradout, 32'(exp));
      chk({tag, " busy@E3"}, 32'(busy), 32'd0);
      tick();  // E4
      chk({tag, " dv@E4"}, 32'(dv_out), 32'd0);
      chk({tag, " hold@E4"}, gradout, 32'(exp));
   endtask

   initial begin
      rst   = 1'b1;
      dv_in = 1'b0;
      sigin = '0;
      errin = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst dv_out", 32'(dv_out), 32'd0);
      chk("rst gradout", gradout, 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      tick();
      chk("idle busy", 32'(busy), 32'd0);

      run_vec("y512 e1024", 512, 1024, 256);
      run_vec("y256 e-2048", 256, -2048, -384);
      run_vec("y0 e5000", 0, 5000, 0);
      run_vec("y-5 e5000", -5, 5000, 0);
      run_vec("y1023 e-4096", 1023, -4096, 0);
      run_vec("y100 e3000", 100, 3000, 264);
      run_vec("y700 e-777", 700, -777, -168);

      // Edge while busy is dropped; a fresh edge at E4 is accepted.
      sigin = 11'sd512;
      errin = 32'sd1024;
      dv_in = 1'b1;
      tick();  // E0
      dv_in = 1'b0;
      tick();  // E1
      chk("drop dv@E1", 32'(dv_out), 32'd0);
      dv_in = 1'b1;
      sigin = 11'sd256;
      errin = -32'sd2048;
      tick();  // E2: edge dropped
      chk("drop dv@E2", 32'(dv_out), 32'd0);
      dv_in = 1'b0;
      tick();  // E3
      chk("drop dv@E3", 32'(dv_out), 32'd1);
      chk("drop grad@E3", gradout, 32'd256);
      dv_in = 1'b1;
      tick();  // E4: new start
      chk("restart busy@E4", 32'(busy), 32'd1);
      chk("restart dv@E4", 32'(dv_out), 32'd0);
      dv_in = 1'b0;
      tick();  // E5
      chk("restart dv@E5", 32'(dv_out), 32'd0);
      tick();  // E6
      chk("restart dv@E6", 32'(dv_out), 32'd0);
      chk("restart hold@E6", gradout, 32'd256);
      tick();  // E7
      chk("restart dv@E7", 32'(dv_out), 32'd1);
      chk("restart grad@E7", gradout, -32'sd384);
      tick();

      // Level held high gives exactly one computation.
      sigin  = 11'sd512;
      errin  = 32'sd1024;
      dv_in  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dv_out) pulses++;
      end
      chk("hold pulses", 32'(pulses), 32'd1);
      chk("hold grad", gradout, 32'd256);
      chk("hold busy", 32'(busy), 32'd0);
      dv_in = 1'b0;
      tick();

      // Reset at E2 aborts; post-reset dv_in high starts a computation.
      dv_in = 1'b1;
      tick();  // E0
      dv_in = 1'b0;
      tick();  // E1
      rst = 1'b1;
      tick();  // E2 with reset
      chk("abort dv", 32'(dv_out), 32'd0);
      chk("abort grad", gradout, 32'd0);
      chk("abort busy", 32'(busy), 32'd0);
      dv_in = 1'b1;
      tick();
      chk("abort dv2", 32'(dv_out), 32'd0);
      chk("rst over start", 32'(busy), 32'd0);
      rst = 1'b0;
      tick();  // first post-reset sampling edge
      chk("post-rst busy@E0", 32'(busy), 32'd1);
      tick();
      tick();
      chk("post-rst dv@E2", 32'(dv_out), 32'd0);
      chk("post-rst grad@E2", gradout, 32'd0);
      tick();
      chk("post-rst dv@E3", 32'(dv_out), 32'd1);
      chk("post-rst grad@E3", gradout, 32'd256);
      tick();
      chk("post-rst dv@E4", 32'(dv_out), 32'd0);
      chk("post-rst no restart", 32'(busy), 32'd0);
      dv_in = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
